alu_issue_wb: RTL

- Issue/writeback stage wrapped around the 16-bit ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand and opcode inputs, then captures the ALU's registered result and flags.
- Writes the result back to the register file.
- Sits directly upstream and downstream of the ALU: it feeds OpA/OpB/Op and consumes Res/FlagReg.

---
 rtl/alu_issue_wb.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_issue_wb.sv
// Issue/writeback stage around the 16-bit ALU: decodes instructions, drives ALU operands, writes results back.
// Define ISSUE_OVERLAP_EN to accept the next instruction during writeback, with forwarding from alu_res.
module alu_issue_wb #(
  parameter int DW       = 16,
  parameter bit RF_CLEAR = 1'b1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   in_instr,
  output logic [DW-1:0] alu_opa,
  output logic [DW-1:0] alu_opb,
  output logic [3:0]    alu_op,
  input  logic [DW-1:0] alu_res,
  input  logic [2:0]    alu_flags,
  output logic          wb_valid,
  output logic [2:0]    wb_rd,
  output logic [DW-1:0] wb_data,
  output logic [2:0]    flags,
  output logic          illegal,
  input  logic [2:0]    dbg_addr,
  output logic [DW-1:0] dbg_data
);

  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDI = 4'd6;

  state_t        state, state_nxt;
  logic [DW-1:0] rf [8];
  logic [2:0]    rd_q;

  logic [3:0]    op;
  logic [2:0]    rd, rs, rt;
  logic [5:0]    imm6;
  logic          op_legal, accept, issue;
  logic [DW-1:0] rs_data, rt_data, opa_src, rt_src, opb_src;

  assign op   = in_instr[15:12];
  assign rd   = in_instr[11:9];
  assign rs   = in_instr[8:6];
  assign rt   = in_instr[5:3];
  assign imm6 = in_instr[5:0];

  assign op_legal = (op <= OP_ADDI);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && op_legal;

  // r0 is hardwired to zero on every read port, so its storage is never consulted.
  assign rs_data  = (rs == 3'd0)       ? '0 : rf[rs];
  assign rt_data  = (rt == 3'd0)       ? '0 : rf[rt];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : rf[dbg_addr];

`ifdef ISSUE_OVERLAP_EN
  // An instruction issued during WB sees rf[rd_q] one edge too early; take the value from the ALU instead.
  logic fwd_ok;
  assign fwd_ok  = (state == WB) && (rd_q != 3'd0);
  assign opa_src = (fwd_ok && rs == rd_q) ? alu_res : rs_data;
  assign rt_src  = (fwd_ok && rt == rd_q) ? alu_res : rt_data;
`else
  assign opa_src = rs_data;
  assign rt_src  = rt_data;
`endif

  assign opb_src = (op == OP_ADDI) ? {{(DW-6){imm6[5]}}, imm6} : rt_src;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
  // in_valid is used instead of accept here to keep in_ready out of its own fan-in.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && op_legal) state_nxt = EXEC;
      end
      EXEC: state_nxt = WB;
      WB: begin
`ifdef ISSUE_OVERLAP_EN
        in_ready  = 1'b1;
        state_nxt = (in_valid && op_legal) ? EXEC : IDLE;
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      alu_opa  <= '0;
      alu_opb  <= '0;
      alu_op   <= '0;
      rd_q     <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      flags    <= '0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= (state == WB);
      illegal  <= accept && !op_legal;
      if (state == WB) begin
        wb_rd   <= rd_q;
        wb_data <= alu_res;
        flags   <= alu_flags;
      end
      if (issue) begin
        alu_opa <= opa_src;
        alu_opb <= opb_src;
        alu_op  <= (op == OP_ADDI) ? OP_ADD : op;
        rd_q    <= rd;
      end
    end
  end

  // NOTE: the register file is only cleared when RF_CLEAR is set; otherwise it keeps its contents
  // through RST, but a reset still blocks the pending writeback.
  always_ff @(posedge CLK) begin
    if (RST) begin
      if (RF_CLEAR) begin
        for (int i = 0; i < 8; i++) rf[i] <= '0;
      end
    end else if (state == WB && rd_q != 3'd0) begin
      rf[rd_q] <= alu_res;
    end
  end

endmodule
